// File: rtl/fp_addsub_issuer.sv
// Issue/response wrapper for a floating-point add/sub unit: one-entry issue register,
// credit-based flow control and an in-order response FIFO with sticky overflow.
module fp_addsub_issuer #(
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 5,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ReqValid_i,
    output logic                  ReqReady_o,
    input  logic                  ReqSub_i,
    input  logic [FP_WIDTH-1:0]   ReqOpA_i,
    input  logic [FP_WIDTH-1:0]   ReqOpB_i,
    input  logic [RND_WIDTH-1:0]  ReqRnd_i,
    input  logic [TAG_WIDTH-1:0]  ReqTag_i,
    output logic                  En_o,
    output logic                  SubSel_o,
    output logic [FP_WIDTH-1:0]   OpA_o,
    output logic [FP_WIDTH-1:0]   OpB_o,
    output logic [RND_WIDTH-1:0]  Rnd_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    input  logic                  UnitReady_i,
    input  logic                  UnitValid_i,
    input  logic [FP_WIDTH-1:0]   UnitRes_i,
    input  logic [TAG_WIDTH-1:0]  UnitTag_i,
    input  logic [STAT_WIDTH-1:0] UnitStatus_i,
    output logic                  RspValid_o,
    input  logic                  RspReady_i,
    output logic [FP_WIDTH-1:0]   RspRes_o,
    output logic [TAG_WIDTH-1:0]  RspTag_o,
    output logic [STAT_WIDTH-1:0] RspStatus_o,
    output logic                  Idle_o,
    output logic                  Overflow_o
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic                 sub;
        logic [FP_WIDTH-1:0]  op_a;
        logic [FP_WIDTH-1:0]  op_b;
        logic [RND_WIDTH-1:0] rnd;
        logic [TAG_WIDTH-1:0] tag;
    } iss_req_t;

    typedef struct packed {
        logic [FP_WIDTH-1:0]   res;
        logic [TAG_WIDTH-1:0]  tag;
        logic [STAT_WIDTH-1:0] status;
    } rsp_t;

    logic             iss_v;
    iss_req_t         iss_q;
    logic [CNT_W-1:0] cnt;
    rsp_t             mem [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fill;
    logic             overflow_q;

    logic accept, issue_fire, rsp_pop, rsp_push, full, empty;
    rsp_t head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover every accepted op until its response is consumed, so the
    // FIFO can only overflow if the unit produces results nobody asked for.
    assign ReqReady_o = (cnt < CNT_W'(RESP_DEPTH)) && (!iss_v || UnitReady_i);
    assign accept     = ReqValid_i && ReqReady_o;
    assign issue_fire = iss_v && UnitReady_i;

    assign full     = (fill == CNT_W'(RESP_DEPTH));
    assign empty    = (fill == '0);
    assign rsp_pop  = !empty && RspReady_i;
    assign rsp_push = UnitValid_i && (!full || rsp_pop);

    assign En_o     = iss_v;
    assign SubSel_o = iss_q.sub;
    assign Rnd_o    = iss_q.rnd;
    assign Tag_o    = iss_q.tag;
    assign OpA_o    = iss_v ? iss_q.op_a : '0;
    assign OpB_o    = iss_v ? iss_q.op_b : '0;

    assign head        = mem[rd_ptr];
    assign RspValid_o  = !empty;
    assign RspRes_o    = head.res;
    assign RspTag_o    = head.tag;
    assign RspStatus_o = head.status;

    assign Idle_o     = (cnt == '0) && !iss_v;
    assign Overflow_o = overflow_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss_v <= 1'b0;
            iss_q <= '0;
        end else if (accept) begin
            iss_v <= 1'b1;
            iss_q <= '{sub: ReqSub_i, op_a: ReqOpA_i, op_b: ReqOpB_i,
                       rnd: ReqRnd_i, tag: ReqTag_i};
        end else if (issue_fire) begin
            iss_v <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            case ({accept, rsp_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (rsp_push)
            mem[wr_ptr] <= '{res: UnitRes_i, tag: UnitTag_i, status: UnitStatus_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (rsp_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rsp_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({rsp_push, rsp_pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
            if (UnitValid_i && !rsp_push)
                overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Directed bench for fp_addsub_issuer; the bench itself plays a zero-latency add/sub unit.
module tb_fp_addsub_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid, ReqReady, ReqSub;
    logic [31:0] ReqOpA, ReqOpB;
    logic [2:0]  ReqRnd;
    logic [3:0]  ReqTag;
    logic        En, SubSel;
    logic [31:0] OpA, OpB;
    logic [2:0]  Rnd;
    logic [3:0]  Tag;
    logic        UnitReady, UnitValid;
    logic [31:0] UnitRes;
    logic [3:0]  UnitTag;
    logic [4:0]  UnitStatus;
    logic        RspValid, RspReady;
    logic [31:0] RspRes;
    logic [3:0]  RspTag;
    logic [4:0]  RspStatus;
    logic        Idle, Overflow;

    logic        force_mode, f_v;
    logic [31:0] f_res;
    logic [3:0]  f_tag;
    logic [4:0]  f_stat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_addsub_issuer dut (
        .clk_i(clk), .rst_i(rst),
        .ReqValid_i(ReqValid), .ReqReady_o(ReqReady), .ReqSub_i(ReqSub),
        .ReqOpA_i(ReqOpA), .ReqOpB_i(ReqOpB), .ReqRnd_i(ReqRnd), .ReqTag_i(ReqTag),
        .En_o(En), .SubSel_o(SubSel), .OpA_o(OpA), .OpB_o(OpB), .Rnd_o(Rnd), .Tag_o(Tag),
        .UnitReady_i(UnitReady), .UnitValid_i(UnitValid), .UnitRes_i(UnitRes),
        .UnitTag_i(UnitTag), .UnitStatus_i(UnitStatus),
        .RspValid_o(RspValid), .RspReady_i(RspReady), .RspRes_o(RspRes),
        .RspTag_o(RspTag), .RspStatus_o(RspStatus),
        .Idle_o(Idle), .Overflow_o(Overflow)
    );

    // Stand-in arithmetic: exact for the 1.0 + 2.0 case, integer add/sub otherwise.
    function automatic logic [31:0] unit_fn(input logic sub, input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000)
            return sub ? 32'hBF80_0000 : 32'h4040_0000;
        return sub ? a - b : a + b;
    endfunction

    always_comb begin
        UnitValid  = En && UnitReady;
        UnitRes    = unit_fn(SubSel, OpA, OpB);
        UnitTag    = Tag;
        UnitStatus = {SubSel, Tag};
        if (force_mode) begin
            UnitValid  = f_v;
            UnitRes    = f_res;
            UnitTag    = f_tag;
            UnitStatus = f_stat;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] exp_res[$];
    logic [3:0]  exp_tag[$];
    int n_acc, sent, got;
    logic [3:0] exp_drain [4];

    initial begin
        rst = 1'b1; ReqValid = 0; ReqSub = 0; ReqOpA = 0; ReqOpB = 0; ReqRnd = 0; ReqTag = 0;
        UnitReady = 1; RspReady = 1;
        force_mode = 0; f_v = 0; f_res = 0; f_tag = 0; f_stat = 0;
        #12;
        check("rst_en", 64'(En), 64'd0);
        check("rst_opa", 64'(OpA), 64'd0);
        check("rst_rspvalid", 64'(RspValid), 64'd0);
        check("rst_reqready", 64'(ReqReady), 64'd1);
        check("rst_idle", 64'(Idle), 64'd1);
        check("rst_overflow", 64'(Overflow), 64'd0);
        tick();
        rst = 1'b0;

        // single add, zero-latency unit
        ReqValid = 1; ReqSub = 0; ReqOpA = 32'h3F80_0000; ReqOpB = 32'h4000_0000;
        ReqRnd = 3'd2; ReqTag = 4'h5;
        #1 check("add_reqready", 64'(ReqReady), 64'd1);
        tick();
        ReqValid = 0;
        #1;
        check("add_en", 64'(En), 64'd1);
        check("add_opa", 64'(OpA), 64'h3F80_0000);
        check("add_opb", 64'(OpB), 64'h4000_0000);
        check("add_rnd", 64'(Rnd), 64'd2);
        check("add_tag", 64'(Tag), 64'h5);
        check("add_rsp_early", 64'(RspValid), 64'd0);
        check("add_busy", 64'(Idle), 64'd0);
        tick(); #1;
        check("add_rspvalid", 64'(RspValid), 64'd1);
        check("add_res", 64'(RspRes), 64'h4040_0000);
        check("add_rsptag", 64'(RspTag), 64'h5);
        check("add_status", 64'(RspStatus), 64'h05);
        check("add_en_clr", 64'(En), 64'd0);
        check("add_opa_zero", 64'(OpA), 64'd0);
        tick(); #1;
        check("add_drained", 64'(RspValid), 64'd0);
        check("add_idle", 64'(Idle), 64'd1);

        // credit limit with response side stalled
        RspReady = 0; ReqValid = 1; ReqOpB = 32'd1; n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            ReqTag = 4'(n_acc);
            ReqOpA = 32'h100 + 32'(n_acc);
            #1;
            if (ReqReady) n_acc++;
            tick();
        end
        ReqValid = 0;
        #1;
        check("credit_accepts", 64'(n_acc), 64'd4);
        check("credit_reqready", 64'(ReqReady), 64'd0);
        check("credit_head_tag", 64'(RspTag), 64'd0);
        RspReady = 1;
        #1 check("credit_head_res", 64'(RspRes), 64'h101);
        tick();
        RspReady = 0;
        #1;
        check("credit_reopen", 64'(ReqReady), 64'd1);
        check("credit_next_tag", 64'(RspTag), 64'd1);
        RspReady = 1;
        for (int i = 1; i < 4; i++) begin
            #1 check("credit_order", 64'(RspTag), 64'(i));
            tick();
        end
        #1;
        check("credit_empty", 64'(RspValid), 64'd0);
        check("credit_idle", 64'(Idle), 64'd1);

        // unit backpressure holds the issue register
        ReqValid = 1; ReqSub = 1; ReqTag = 4'h9; ReqOpA = 32'hAAAA_0000; ReqOpB = 32'h0000_5555;
        #1;
        tick();
        ReqValid = 0; UnitReady = 0;
        ReqOpA = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_en", 64'(En), 64'd1);
            check("stall_opa", 64'(OpA), 64'hAAAA_0000);
            check("stall_opb", 64'(OpB), 64'h5555);
            check("stall_reqready", 64'(ReqReady), 64'd0);
            check("stall_rsp", 64'(RspValid), 64'd0);
            tick();
        end
        UnitReady = 1;
        #1 check("stall_release_ready", 64'(ReqReady), 64'd1);
        check("stall_subsel", 64'(SubSel), 64'd1);
        tick(); #1;
        check("stall_en_clr", 64'(En), 64'd0);
        check("stall_rspvalid", 64'(RspValid), 64'd1);
        check("stall_rsptag", 64'(RspTag), 64'h9);
        check("stall_res", 64'(RspRes), 64'hAAA9_AAAB);
        check("stall_status", 64'(RspStatus), 64'h19);
        tick(); #1;
        check("stall_idle", 64'(Idle), 64'd1);

        // streamed tags with random response backpressure
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            RspReady = 1'($urandom_range(0, 1));
            ReqValid = (sent < 8);
            ReqTag   = 4'(sent);
            ReqSub   = 1'(sent);
            ReqOpA   = $urandom;
            ReqOpB   = $urandom;
            #1;
            if (ReqValid && ReqReady) begin
                exp_res.push_back(unit_fn(ReqSub, ReqOpA, ReqOpB));
                exp_tag.push_back(ReqTag);
                sent++;
            end
            if (RspValid && RspReady) begin
                if (exp_tag.size() == 0) begin
                    check("stream_spurious", 64'd1, 64'd0);
                end else begin
                    check("stream_tag", 64'(RspTag), 64'(exp_tag.pop_front()));
                    check("stream_res", 64'(RspRes), 64'(exp_res.pop_front()));
                end
                got++;
            end
            tick();
        end
        ReqValid = 0; RspReady = 0;
        #1;
        check("stream_count", 64'(got), 64'd8);
        check("stream_idle", 64'(Idle), 64'd1);
        check("stream_overflow", 64'(Overflow), 64'd0);
        check("stream_empty", 64'(RspValid), 64'd0);

        // forced results into a full buffer
        force_mode = 1; f_v = 1;
        for (int i = 0; i < 4; i++) begin
            f_tag = 4'(i); f_res = 32'h1000 + 32'(i); f_stat = 5'(i);
            #1;
            tick();
        end
        f_tag = 4'd4; f_res = 32'h1004;
        #1;
        check("ovf_not_yet", 64'(Overflow), 64'd0);
        check("ovf_full_valid", 64'(RspValid), 64'd1);
        tick();
        f_v = 0;
        #1;
        check("ovf_set", 64'(Overflow), 64'd1);
        check("ovf_head_kept", 64'(RspTag), 64'd0);
        f_v = 1; f_tag = 4'd7; f_res = 32'h1007; f_stat = 5'd7; RspReady = 1;
        #1;
        tick();
        f_v = 0;
        exp_drain[0] = 4'd1; exp_drain[1] = 4'd2; exp_drain[2] = 4'd3; exp_drain[3] = 4'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ovf_drain_tag", 64'(RspTag), 64'(exp_drain[i]));
            check("ovf_drain_res", 64'(RspRes), 64'h1000 + 64'(exp_drain[i]));
            tick();
        end
        #1;
        check("ovf_empty", 64'(RspValid), 64'd0);
        check("ovf_sticky", 64'(Overflow), 64'd1);
        rst = 1;
        #1 check("ovf_reset_clr", 64'(Overflow), 64'd0);
        tick();
        rst = 0; force_mode = 0; RspReady = 0;

        // asynchronous reset with three results buffered
        ReqValid = 1; ReqSub = 0; ReqOpA = 32'd10; ReqOpB = 32'd20;
        for (int i = 0; i < 3; i++) begin
            ReqTag = 4'(i + 1);
            #1;
            tick();
        end
        ReqValid = 0;
        tick(); #1;
        check("mid_buffered", 64'(RspValid), 64'd1);
        check("mid_busy", 64'(Idle), 64'd0);
        rst = 1;
        #1;
        check("mid_rst_rspvalid", 64'(RspValid), 64'd0);
        check("mid_rst_idle", 64'(Idle), 64'd1);
        check("mid_rst_en", 64'(En), 64'd0);
        check("mid_rst_reqready", 64'(ReqReady), 64'd1);
        tick();
        rst = 0; RspReady = 1;
        ReqValid = 1; ReqTag = 4'hC; ReqOpA = 32'd1; ReqOpB = 32'd2;
        #1;
        tick();
        ReqValid = 0;
        tick(); #1;
        check("post_rst_valid", 64'(RspValid), 64'd1);
        check("post_rst_tag", 64'(RspTag), 64'hC);
        check("post_rst_res", 64'(RspRes), 64'd3);
        tick(); #1;
        check("post_rst_idle", 64'(Idle), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
